// File: rtl/spi_master_pkg.sv
// Shared types and constants for the SPI master.
//   state_t : controller states
//   dbg_t   : debug view of the controller (state, bit counter, SCLK edge ticks)
package spi_master_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } state_t;

    localparam int   FRAME_BITS = 16;
    localparam int   ADDR_BITS  = 7;
    localparam int   DATA_BITS  = 8;
    localparam logic RW_READ    = 1'b1;

    typedef struct packed {
        state_t     state;
        logic [4:0] bit_cnt;
        logic       sclk_rise;
        logic       sclk_fall;
    } dbg_t;

endpackage

// File: rtl/spi_clkgen.sv
// SCLK divider for the SPI master.
//   clk, reset     : system clock, synchronous active-high reset
//   run_i          : advance the divider counter
//   clear_i        : force counter to 0 and SCLK low
//   toggle_i       : let SCLK toggle at the end of each CLKDIV-cycle phase
//   sclk_o         : registered SCLK level
//   phase_end_o    : last cycle of the current CLKDIV-cycle phase
//   rise_tick_o    : first cycle with SCLK high
//   fall_tick_o    : first cycle with SCLK low after a high phase
//   sample_tick_o  : last cycle of an SCLK high phase
module spi_clkgen #(
    parameter int CLKDIV = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic run_i,
    input  logic clear_i,
    input  logic toggle_i,
    output logic sclk_o,
    output logic phase_end_o,
    output logic rise_tick_o,
    output logic fall_tick_o,
    output logic sample_tick_o
);

    localparam logic [7:0] DIV_LAST = 8'(CLKDIV - 1);

    logic [7:0] div_cnt_q, div_cnt_d;
    logic       sclk_q, sclk_d;
    logic       rise_q, rise_d;
    logic       fall_q, fall_d;
    logic       wrap;

    assign wrap = run_i && (div_cnt_q == DIV_LAST);

    always_comb begin
        div_cnt_d = div_cnt_q;
        sclk_d    = sclk_q;
        if (clear_i) begin
            div_cnt_d = '0;
            sclk_d    = 1'b0;
        end else if (run_i) begin
            div_cnt_d = wrap ? 8'd0 : div_cnt_q + 8'd1;
            if (wrap && toggle_i) begin
                sclk_d = !sclk_q;
            end
        end
        rise_d = !sclk_q && sclk_d;
        fall_d = sclk_q && !sclk_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt_q <= '0;
            sclk_q    <= 1'b0;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            sclk_q    <= sclk_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
        end
    end

    assign sclk_o        = sclk_q;
    assign phase_end_o   = wrap;
    assign rise_tick_o   = rise_q;
    assign fall_tick_o   = fall_q;
    // Closing edge of this cycle drops SCLK: the slave has had a full high
    // phase to present its bit, so this is where the master captures.
    assign sample_tick_o = wrap && toggle_i && sclk_q;

endmodule

// File: rtl/spi_master.sv
// SPI master: turns a one-cycle read/write request into a 16-bit MSB-first
// frame {addr[6:0], rw, data[7:0]}.
//   clk, reset        : system clock, synchronous active-high reset
//   start, rw, addr,
//   wdata             : request; accepted only while busy=0
//   busy              : transaction in progress (includes the CS gap)
//   done              : one-cycle pulse at end of frame
//   rdata             : read result, updated at done of a read
//   sclk_pin, cs_pin,
//   mosi_pin, miso_pin: SPI pins (SCLK idles low, CS active low)
//   dbg               : controller state / bit counter / SCLK edge ticks
// Handshake: start is a level sampled on every clock where busy=0; a sampled
// start launches a frame and busy rises the next cycle. Requests made while
// busy=1 are dropped.
module spi_master
    import spi_master_pkg::*;
#(
    parameter int CLKDIV = 8,
    parameter int CS_GAP = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 rw,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [DATA_BITS-1:0] wdata,
    output logic                 busy,
    output logic                 done,
    output logic [DATA_BITS-1:0] rdata,
    output logic                 sclk_pin,
    output logic                 cs_pin,
    output logic                 mosi_pin,
    input  logic                 miso_pin,
    output dbg_t                 dbg
);

    localparam logic [7:0] GAP_LAST = 8'(CS_GAP - 1);
    localparam logic [4:0] LAST_BIT = 5'(FRAME_BITS - 1);

    state_t state_q, state_d;

    logic [FRAME_BITS-1:0] shift_out_q, shift_out_d;
    logic [DATA_BITS-1:0]  shift_in_q, shift_in_d;
    logic [DATA_BITS-1:0]  rdata_q, rdata_d;
    logic [4:0]            bit_cnt_q, bit_cnt_d;
    logic [7:0]            gap_cnt_q, gap_cnt_d;
    logic                  rw_q, rw_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  cs_q, cs_d;
    logic                  mosi_q, mosi_d;

    logic gen_run, gen_clear, gen_toggle;
    logic sclk_lvl, phase_end, rise_tick, fall_tick, sample_tick;

    assign gen_run    = (state_q == SETUP) || (state_q == SHIFT) || (state_q == HOLD);
    assign gen_clear  = (state_q == IDLE) || (state_q == GAP);
    assign gen_toggle = (state_q == SHIFT);

    spi_clkgen #(.CLKDIV(CLKDIV)) u_clkgen (
        .clk          (clk),
        .reset        (reset),
        .run_i        (gen_run),
        .clear_i      (gen_clear),
        .toggle_i     (gen_toggle),
        .sclk_o       (sclk_lvl),
        .phase_end_o  (phase_end),
        .rise_tick_o  (rise_tick),
        .fall_tick_o  (fall_tick),
        .sample_tick_o(sample_tick)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SETUP;
            SETUP:   if (phase_end) state_d = SHIFT;
            SHIFT:   if (sample_tick && (bit_cnt_q == LAST_BIT)) state_d = HOLD;
            HOLD:    if (phase_end) state_d = GAP;
            GAP:     if (gap_cnt_q == GAP_LAST) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and output next values. Pins are registered from the
    // next-state values so they change on the same edge as the state.
    always_comb begin
        shift_out_d = shift_out_q;
        shift_in_d  = shift_in_q;
        bit_cnt_d   = bit_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        rw_d        = rw_q;
        rdata_d     = rdata_q;
        case (state_q)
            IDLE: begin
                bit_cnt_d = '0;
                gap_cnt_d = '0;
                if (start) begin
                    shift_out_d = {addr, rw, wdata};
                    rw_d        = rw;
                    shift_in_d  = '0;
                end
            end
            SHIFT: begin
                if (sample_tick) begin
                    shift_out_d = {shift_out_q[FRAME_BITS-2:0], 1'b0};
                    bit_cnt_d   = bit_cnt_q + 5'd1;
                    // Only the data byte is captured; miso is undriven
                    // during the command byte.
                    if ((rw_q == RW_READ) && (bit_cnt_q >= 5'd8)) begin
                        shift_in_d = {shift_in_q[DATA_BITS-2:0], miso_pin};
                    end
                end
            end
            HOLD: begin
                if (phase_end && (rw_q == RW_READ)) begin
                    rdata_d = shift_in_q;
                end
            end
            GAP: begin
                gap_cnt_d = gap_cnt_q + 8'd1;
            end
            default: ;
        endcase
        busy_d = (state_d != IDLE);
        cs_d   = !((state_d == SETUP) || (state_d == SHIFT) || (state_d == HOLD));
        done_d = (state_q == HOLD) && (state_d == GAP);
        // mosi tracks the MSB of the shifter, so it moves exactly when SCLK falls
        mosi_d = shift_out_d[FRAME_BITS-1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_out_q <= '0;
            shift_in_q  <= '0;
            rdata_q     <= '0;
            bit_cnt_q   <= '0;
            gap_cnt_q   <= '0;
            rw_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cs_q        <= 1'b1;
            mosi_q      <= 1'b0;
        end else begin
            shift_out_q <= shift_out_d;
            shift_in_q  <= shift_in_d;
            rdata_q     <= rdata_d;
            bit_cnt_q   <= bit_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            rw_q        <= rw_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cs_q        <= cs_d;
            mosi_q      <= mosi_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign rdata    = rdata_q;
    assign sclk_pin = sclk_lvl;
    assign cs_pin   = cs_q;
    assign mosi_pin = mosi_q;

    always_comb begin
        dbg.state     = state_q;
        dbg.bit_cnt   = bit_cnt_q;
        dbg.sclk_rise = rise_tick;
        dbg.sclk_fall = fall_tick;
    end

endmodule

// File: tb/tb_spi_master.sv
module tb_spi_master;
  import spi_master_pkg::*;

  localparam int CSG = 8;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // stimulus
  logic       start8 = 1'b0;
  logic       start4 = 1'b0;
  logic       rw = 1'b0;
  logic [6:0] addr = '0;
  logic [7:0] wdata = '0;
  logic       sel = 1'b0;   // 0: CLKDIV=8 instance, 1: CLKDIV=4 instance
  wire        miso;

  logic       busy8, done8, sclk8, cs8, mosi8;
  logic       busy4, done4, sclk4, cs4, mosi4;
  logic [7:0] rdata8, rdata4;
  dbg_t       dbg8, dbg4;

  spi_master #(.CLKDIV(8), .CS_GAP(CSG)) u_dut8 (
    .clk(clk), .reset(reset), .start(start8), .rw(rw), .addr(addr), .wdata(wdata),
    .busy(busy8), .done(done8), .rdata(rdata8), .sclk_pin(sclk8), .cs_pin(cs8),
    .mosi_pin(mosi8), .miso_pin(miso), .dbg(dbg8)
  );

  spi_master #(.CLKDIV(4), .CS_GAP(CSG)) u_dut4 (
    .clk(clk), .reset(reset), .start(start4), .rw(rw), .addr(addr), .wdata(wdata),
    .busy(busy4), .done(done4), .rdata(rdata4), .sclk_pin(sclk4), .cs_pin(cs4),
    .mosi_pin(mosi4), .miso_pin(miso), .dbg(dbg4)
  );

  logic       s_sclk, s_cs, s_mosi, s_done, s_busy;
  logic [7:0] s_rdata;
  assign s_sclk  = sel ? sclk4  : sclk8;
  assign s_cs    = sel ? cs4    : cs8;
  assign s_mosi  = sel ? mosi4  : mosi8;
  assign s_done  = sel ? done4  : done8;
  assign s_busy  = sel ? busy4  : busy8;
  assign s_rdata = sel ? rdata4 : rdata8;

  // slave memory model, sampled on the falling clk edge
  logic [7:0]  mem [0:127];
  logic        prev_cs = 1'b1, prev_sclk = 1'b0, prev_mosi = 1'b0, rd_flag = 1'b0;
  logic        miso_r = 1'bz;
  logic [15:0] rx = '0;
  logic [7:0]  tx = '0;
  int          rise_n = 0, last_rises = 0, mosi_viol = 0, high_cnt = 0, last_gap = 0, done_cnt = 0;
  logic [15:0] got_q[$];
  logic [15:0] exp_q[$];
  assign miso = miso_r;

  always @(negedge clk) begin
    if (s_done) done_cnt++;
    if (s_cs) high_cnt++;
    if (!s_cs && prev_cs) begin
      last_gap = high_cnt; high_cnt = 0; rise_n = 0; rx = '0; rd_flag = 1'b0; miso_r = 1'bx;
    end
    if (!s_cs) begin
      if (s_sclk && !prev_sclk) begin
        rx = {rx[14:0], s_mosi};
        rise_n++;
        if (rise_n == 8) begin rd_flag = rx[0]; tx = mem[rx[7:1]]; end
      end
      if (!s_sclk && prev_sclk && rd_flag && rise_n >= 8 && rise_n < 16) miso_r = tx[3'(15 - rise_n)];
      if (s_sclk && (s_mosi !== prev_mosi)) mosi_viol++;
    end
    if (s_cs && !prev_cs) begin
      last_rises = rise_n;
      got_q.push_back(rx);
      if (rise_n == 16 && !rx[8]) mem[rx[15:9]] = rx[7:0];
      miso_r = 1'bz;
    end
    prev_cs = s_cs; prev_sclk = s_sclk; prev_mosi = s_mosi;
  end

  // scoreboard counters
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // driver: one request on the selected instance; returns start-to-done latency
  task automatic run_frame(input logic r, input logic [6:0] a, input logic [7:0] d,
                           output int lat, output logic [7:0] rd_at_done);
    int  t0;
    bit  seen;
    @(negedge clk);
    rw = r; addr = a; wdata = d;
    if (sel) start4 = 1'b1; else start8 = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start4 = 1'b0; start8 = 1'b0;
    seen = 1'b0; lat = -1; rd_at_done = 'x;
    for (int i = 0; i < 3000 && !seen; i++) begin
      if (s_done) begin seen = 1'b1; lat = cyc - t0; rd_at_done = s_rdata; end
      else @(negedge clk);
    end
    for (int i = 0; i < 100 && s_busy; i++) @(negedge clk);
    repeat (3) @(negedge clk);
  endtask

  int         lat;
  logic [7:0] rd;
  int         edges, dc0;
  logic       psclk;
  logic [15:0] e, g;

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 8'h00;

    // reset values
    @(negedge clk);
    check("rst_busy", 32'(busy8), 0);
    check("rst_done", 32'(done8), 0);
    check("rst_rdata", 32'(rdata8), 0);
    check("rst_sclk", 32'(sclk8), 0);
    check("rst_cs", 32'(cs8), 1);
    check("rst_mosi", 32'(mosi8), 0);
    check("rst_state", 32'(dbg8.state), 32'(IDLE));
    check("rst_cs4", 32'(cs4), 1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // write 0xA5 to 0x05, CLKDIV=8
    run_frame(1'b0, 7'h05, 8'hA5, lat, rd);
    check("wr_frame", 32'(got_q[$]), 32'h0AA5);
    check("wr_rises", 32'(last_rises), 16);
    check("wr_latency", 32'(lat), 273);
    check("wr_rdata", 32'(rdata8), 0);
    check("wr_mem", 32'(mem[5]), 32'hA5);

    // read 0x05 returning 0x3C
    mem[5] = 8'h3C;
    run_frame(1'b1, 7'h05, 8'h00, lat, rd);
    check("rd_byte0", 32'(got_q[$][15:8]), 32'h0B);
    check("rd_at_done", 32'(rd), 32'h3C);
    check("rd_latency", 32'(lat), 273);
    repeat (1000) @(negedge clk);
    check("rd_hold", 32'(rdata8), 32'h3C);

    // reset at the 9th SCLK rising edge of a read
    @(negedge clk);
    rw = 1'b1; addr = 7'h05; wdata = 8'h00; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    dc0 = done_cnt; edges = 0; psclk = 1'b0;
    for (int i = 0; i < 2000 && edges < 9; i++) begin
      @(negedge clk);
      if (s_sclk && !psclk) edges++;
      psclk = s_sclk;
    end
    check("rst_mid_edges", 32'(edges), 9);
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_cs", 32'(cs8), 1);
    check("rst_mid_sclk", 32'(sclk8), 0);
    check("rst_mid_busy", 32'(busy8), 0);
    reset = 1'b0;
    repeat (400) @(negedge clk);
    check("rst_mid_nodone", 32'(done_cnt), 32'(dc0));
    check("rst_mid_rdata", 32'(rdata8), 0);

    // start held high: only frames accepted while idle, each intact
    exp_q.delete(); got_q.delete();
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      addr = 7'(i + 3); wdata = 8'(i * 7 + 1); rw = 1'b0; start8 = 1'b1;
      if (!s_busy) exp_q.push_back({addr, 1'b0, wdata});
    end
    @(negedge clk);
    start8 = 1'b0;
    for (int i = 0; i < 1000 && s_busy; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("pulse_accepts", 32'(exp_q.size()), 2);
    check("pulse_frames", 32'(got_q.size()), 2);
    check("pulse_cs_gap", 32'(last_gap), 32'(CSG + 1));
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      check("pulse_frame_data", 32'(g), 32'(e));
    end

    // integration with the memory model: no aliasing between 0x7F and 0x00
    run_frame(1'b0, 7'h7F, 8'h5A, lat, rd);
    run_frame(1'b1, 7'h7F, 8'h00, lat, rd);
    check("int_rd_7f", 32'(rd), 32'h5A);
    run_frame(1'b0, 7'h00, 8'hC3, lat, rd);
    check("int_wr_keeps_rdata", 32'(rdata8), 32'h5A);
    run_frame(1'b1, 7'h7F, 8'h00, lat, rd);
    check("int_rd_7f_again", 32'(rd), 32'h5A);
    run_frame(1'b1, 7'h00, 8'h00, lat, rd);
    check("int_rd_00", 32'(rd), 32'hC3);

    // CLKDIV=4 instance
    sel = 1'b1;
    repeat (2) @(negedge clk);
    run_frame(1'b0, 7'h01, 8'hFF, lat, rd);
    check("div4_wr_latency", 32'(lat), 137);
    check("div4_wr_frame", 32'(got_q[$]), 32'h02FF);
    run_frame(1'b1, 7'h01, 8'h00, lat, rd);
    check("div4_rd_data", 32'(rd), 32'hFF);
    check("div4_rd_latency", 32'(lat), 137);
    check("div4_rises", 32'(last_rises), 16);

    check("mosi_stable_high", 32'(mosi_viol), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
